flit_output_arbiter: RTL

Wormhole output-port arbiter for one router output in the NoC. It shares a single 32-bit valid/ready flit channel between N input ports. Packets are granted round-robin on head flits, and the grant is held until the tail flit transfers. It sits between the router's input buffers and the link toward the neighbouring node or local Node port.

---
 rtl/flit_output_arbiter_if.sv | 44 ++++
 rtl/flit_output_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/flit_output_arbiter_if.sv
// -----------------------------------------------------------------------------
// flit_output_arbiter_if
//
// Purpose : Bundles the shared flit channel of one router output port: the N
//           upstream valid/ready flit inputs, the single downstream
//           valid/ready flit output, and the arbitration status.
//
// Signals :
//   in_data   [N*DATA_WIDTH] flit from input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid  [N]            per-input valid
//   in_ready  [N]            per-input ready (driven by the arbiter)
//   out_data  [DATA_WIDTH]   forwarded flit
//   out_valid                output valid
//   out_ready                downstream ready
//   grant     [N]            one-hot owner of the output, 0 when idle
//   busy                     high while a packet holds the output
//
// Modports:
//   master : arbiter side (drives in_ready, out_*, grant, busy)
//   slave  : environment side (drives in_data, in_valid, out_ready)
// -----------------------------------------------------------------------------
interface flit_output_arbiter_if #(
    parameter int N          = 5,
    parameter int DATA_WIDTH = 32
);
    logic [N*DATA_WIDTH-1:0] in_data;
    logic [N-1:0]            in_valid;
    logic [N-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [N-1:0]            grant;
    logic                    busy;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, grant, busy
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, grant, busy
    );
endinterface

// File: rtl/flit_output_arbiter.sv
// -----------------------------------------------------------------------------
// flit_output_arbiter
//
// Purpose : Wormhole output-port arbiter. Shares one valid/ready flit channel
//           between N inputs. A packet is granted round-robin on its head
//           flit and keeps the output until its tail flit has transferred.
//           Flit type lives in the top two bits: 1 head, 2 body, 3 tail,
//           0 is treated as body.
//
// Ports   :
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   flit_output_arbiter_if.master (inputs, output, grant, busy)
//
// Build option:
//   ARB_OUTPUT_REG_EN  undefined -> combinational pass-through from the
//                      granted input to the output (zero latency).
//                      defined   -> 2-entry skid buffer between the mux and
//                      the output; in_ready comes only from registered
//                      state, one extra cycle of flit latency.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; head-flit requests are arbitrated, nothing transfers
// LOCKED| granted input streams flits until its tail flit transfers
// -----------------------------------------------------------------------------
module flit_output_arbiter #(
    parameter int N          = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    flit_output_arbiter_if.master  bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] FT_HEAD = 2'd1;
    localparam logic [1:0] FT_TAIL = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0]   r_gidx, w_gidx_nxt;
    logic [N-1:0]    r_grant, w_grant_nxt;
    logic            r_busy, w_busy_nxt;

    logic [N-1:0]    w_req;
    logic            w_any_req;
    logic [PW-1:0]   w_winner;

    logic [DATA_WIDTH-1:0] w_src_data;
    logic            w_src_valid;
    logic            w_src_ready;
    logic            w_src_xfer;
    logic            w_src_tail;

    // ------------------------------------------------------------------
    // Head-flit requests (only meaningful while IDLE)
    // ------------------------------------------------------------------
    always_comb begin
        w_req = '0;
        for (int i = 0; i < N; i++) begin
            w_req[i] = bus.in_valid[i] &&
                       (bus.in_data[i*DATA_WIDTH + DATA_WIDTH - 2 +: 2] == FT_HEAD);
        end
    end

    // First requester at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int idx;
        idx       = 0;
        w_any_req = 1'b0;
        w_winner  = '0;
        for (int j = 0; j < N; j++) begin
            idx = int'(r_rr_ptr) + j;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_any_req && w_req[idx]) begin
                w_any_req = 1'b1;
                w_winner  = PW'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Granted source
    // ------------------------------------------------------------------
    assign w_src_data  = bus.in_data[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_src_valid = r_busy && bus.in_valid[r_gidx];
    assign w_src_xfer  = w_src_valid && w_src_ready;
    assign w_src_tail  = (w_src_data[DATA_WIDTH-1 -: 2] == FT_TAIL);

    // grant is zero while idle, so this also forces all in_ready low in IDLE.
    assign bus.in_ready = r_grant & {N{w_src_ready}};
    assign bus.grant    = r_grant;
    assign bus.busy     = r_busy;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_gidx   <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_gidx   <= w_gidx_nxt;
            r_grant  <= w_grant_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_gidx_nxt   = r_gidx;
        w_grant_nxt  = r_grant;
        w_busy_nxt   = r_busy;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_LOCKED;
                    w_gidx_nxt  = w_winner;
                    w_grant_nxt = {{(N-1){1'b0}}, 1'b1} << w_winner;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_LOCKED: begin
                // Head and body flits pass through; only a tail releases.
                if (w_src_xfer && w_src_tail) begin
                    w_state_nxt  = ST_IDLE;
                    w_grant_nxt  = '0;
                    w_busy_nxt   = 1'b0;
                    w_rr_ptr_nxt = (r_gidx == PW'(N-1)) ? '0 : r_gidx + PW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

`ifdef ARB_OUTPUT_REG_EN
    // ------------------------------------------------------------------
    // Output skid buffer. in_ready depends only on the registered fill
    // level, breaking the out_ready -> in_ready path. Two entries keep one
    // flit per cycle flowing while a stall propagates back by a cycle.
    // The slice drains on its own, so a new grant may start while the
    // previous tail is still queued here; FIFO order keeps packets intact.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_skid_data [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    logic                  w_pop;

    assign w_src_ready = (r_count != 2'd2);
    assign w_pop       = (r_count != 2'd0) && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                r_skid_data[k] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_src_xfer) begin
                r_skid_data[r_wr_ptr] <= w_src_data;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_src_xfer, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = (r_count != 2'd0) ? r_skid_data[r_rd_ptr] : '0;
`else
    // Pass-through: output follows the granted input combinationally.
    assign w_src_ready   = bus.out_ready;
    assign bus.out_valid = w_src_valid;
    assign bus.out_data  = r_busy ? w_src_data : '0;
`endif

endmodule
